// File: rtl/player_attack_seq_if.sv
// -----------------------------------------------------------------------------
// player_attack_seq_if
// Bundles the signals exchanged between the attack sequencer and its
// surroundings: the frame tick, the run enable, the button requests and the
// cancel input, plus the status outputs that feed the sprite and hitbox logic.
//
// Modports:
//   master : the environment. Drives SCEN, attack_enable, attack_req and
//            cancel; observes every sequencer output.
//   slave  : the sequencer. Receives the inputs and drives attack_active,
//            attack_type, attack_frame, attack_busy, attack_start and
//            in_cooldown.
// -----------------------------------------------------------------------------
interface player_attack_seq_if #(
  parameter int NUM_ATK = 3,
  parameter int FRAME_W = 6
);
  localparam int ID_W = $clog2(NUM_ATK + 1);

  logic               SCEN;
  logic               attack_enable;
  logic [NUM_ATK-1:0] attack_req;
  logic               cancel;

  logic               attack_active;
  logic [ID_W-1:0]    attack_type;
  logic [FRAME_W-1:0] attack_frame;
  logic               attack_busy;
  logic               attack_start;
  logic               in_cooldown;

  modport master (
    output SCEN, attack_enable, attack_req, cancel,
    input  attack_active, attack_type, attack_frame, attack_busy,
           attack_start, in_cooldown
  );

  modport slave (
    input  SCEN, attack_enable, attack_req, cancel,
    output attack_active, attack_type, attack_frame, attack_busy,
           attack_start, in_cooldown
  );
endinterface

// File: rtl/player_attack_seq.sv
// -----------------------------------------------------------------------------
// player_attack_seq
// Attack sequencer for one fighter. Button rises are buffered for a limited
// number of frame ticks, the buffered attack is played out frame by frame with
// its own hitbox window, and a recovery cooldown follows each attack. A
// level-sensitive cancel (hit-stun) aborts everything on the next clock.
//
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : player_attack_seq_if.slave
//            in : SCEN (one-clk frame tick), attack_enable, attack_req, cancel
//            out: attack_active, attack_type (0 = none, i+1 = attack i),
//                 attack_frame, attack_busy, attack_start, in_cooldown
//
// Build option:
//   ATK_COMBO_CHAIN_EN - when defined, a buffered request for a higher-index
//   attack may chain into a new attack once the current one is past its
//   hitbox window, skipping the remaining frames and the cooldown.
// -----------------------------------------------------------------------------
module player_attack_seq #(
  parameter int                         NUM_ATK         = 3,
  parameter int                         FRAME_W         = 6,
  parameter logic [NUM_ATK*FRAME_W-1:0] ATK_TOTAL       = {6'd12, 6'd26, 6'd18},
  parameter logic [NUM_ATK*FRAME_W-1:0] ATK_ACT_START   = {6'd2, 6'd8, 6'd4},
  parameter logic [NUM_ATK*FRAME_W-1:0] ATK_ACT_END     = {6'd5, 6'd16, 6'd10},
  parameter int                         RECOVERY_FRAMES = 4,
  parameter int                         BUF_FRAMES      = 6
) (
  input logic                clk,
  input logic                reset,
  player_attack_seq_if.slave bus
);
  localparam int ID_W  = $clog2(NUM_ATK + 1);
  // Tables are padded to a power of two so any ID_W-bit index stays in range.
  localparam int TBL_N = 1 << ID_W;
  localparam int AGE_W = $clog2(BUF_FRAMES + 1);
  localparam int CD_W  = (RECOVERY_FRAMES > 0) ? $clog2(RECOVERY_FRAMES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ATTACK, COOLDOWN} state_t;

  // Per-attack timing tables unpacked from the packed parameters.
  logic [FRAME_W-1:0] total_tbl [TBL_N];
  logic [FRAME_W-1:0] start_tbl [TBL_N];
  logic [FRAME_W-1:0] end_tbl   [TBL_N];

  genvar gi;
  generate
    for (gi = 0; gi < TBL_N; gi++) begin : g_tbl
      if (gi < NUM_ATK) begin : g_used
        assign total_tbl[gi] = ATK_TOTAL[gi*FRAME_W +: FRAME_W];
        assign start_tbl[gi] = ATK_ACT_START[gi*FRAME_W +: FRAME_W];
        assign end_tbl[gi]   = ATK_ACT_END[gi*FRAME_W +: FRAME_W];
      end else begin : g_pad
        assign total_tbl[gi] = '0;
        assign start_tbl[gi] = '0;
        assign end_tbl[gi]   = '0;
      end
    end
  endgenerate

  state_t             state_reg,         state_next;
  logic [NUM_ATK-1:0] req_d_reg;
  logic               pending_valid_reg, pending_valid_next;
  logic [ID_W-1:0]    pending_id_reg,    pending_id_next;
  logic [AGE_W-1:0]   age_reg,           age_next;
  logic [ID_W-1:0]    atk_id_reg,        atk_id_next;
  logic [ID_W-1:0]    type_reg,          type_next;
  logic [FRAME_W-1:0] frame_reg,         frame_next;
  logic               busy_reg,          busy_next;
  logic               active_reg,        active_next;
  logic               start_reg,         start_next;
  logic               cooldown_reg,      cooldown_next;
  logic [CD_W-1:0]    cd_cnt_reg,        cd_cnt_next;

  logic [NUM_ATK-1:0] rise;
  logic [ID_W-1:0]    rise_id;
  logic               tick;
  logic               capture;
  logic               launch;
  logic               consume;
  logic               chain_ok;
  logic [FRAME_W-1:0] frame_inc;

  assign rise      = bus.attack_req & ~req_d_reg;
  assign tick      = bus.SCEN & bus.attack_enable;
  assign capture   = bus.attack_enable & (|rise);
  assign frame_inc = frame_reg + FRAME_W'(1);

  // Lowest-index rise wins when several buttons rise on the same clock.
  always_comb begin
    rise_id = '0;
    for (int i = NUM_ATK - 1; i >= 0; i--) begin
      if (rise[i]) rise_id = ID_W'(i);
    end
  end

`ifdef ATK_COMBO_CHAIN_EN
  assign chain_ok = pending_valid_reg && (pending_id_reg > atk_id_reg) &&
                    (frame_reg > end_tbl[atk_id_reg]);
`else
  assign chain_ok = 1'b0;
`endif

  always_comb begin
    state_next         = state_reg;
    pending_valid_next = pending_valid_reg;
    pending_id_next    = pending_id_reg;
    age_next           = age_reg;
    atk_id_next        = atk_id_reg;
    type_next          = type_reg;
    frame_next         = frame_reg;
    busy_next          = busy_reg;
    active_next        = active_reg;
    start_next         = 1'b0;
    cooldown_next      = cooldown_reg;
    cd_cnt_next        = cd_cnt_reg;
    launch             = 1'b0;
    consume            = 1'b0;

    if (bus.cancel) begin
      // Hit-stun: drop everything, including any buffered request.
      state_next         = IDLE;
      pending_valid_next = 1'b0;
      pending_id_next    = '0;
      age_next           = '0;
      atk_id_next        = '0;
      type_next          = '0;
      frame_next         = '0;
      busy_next          = 1'b0;
      active_next        = 1'b0;
      cooldown_next      = 1'b0;
      cd_cnt_next        = '0;
    end else begin
      if (tick) begin
        unique case (state_reg)
          IDLE: begin
            if (pending_valid_reg) launch = 1'b1;
          end
          ATTACK: begin
            if (chain_ok) begin
              launch = 1'b1;
            end else if (frame_reg == total_tbl[atk_id_reg] - FRAME_W'(1)) begin
              busy_next   = 1'b0;
              type_next   = '0;
              frame_next  = '0;
              active_next = 1'b0;
              if (RECOVERY_FRAMES > 0) begin
                cooldown_next = 1'b1;
                cd_cnt_next   = CD_W'(RECOVERY_FRAMES);
                state_next    = COOLDOWN;
              end else begin
                state_next = IDLE;
              end
            end else begin
              frame_next  = frame_inc;
              active_next = (frame_inc >= start_tbl[atk_id_reg]) &&
                            (frame_inc <= end_tbl[atk_id_reg]);
            end
          end
          COOLDOWN: begin
            cd_cnt_next = cd_cnt_reg - CD_W'(1);
            if (cd_cnt_reg == CD_W'(1)) begin
              cooldown_next = 1'b0;
              state_next    = IDLE;
            end
          end
          default: state_next = IDLE;
        endcase

        if (launch) begin
          consume       = 1'b1;
          state_next    = ATTACK;
          atk_id_next   = pending_id_reg;
          type_next     = pending_id_reg + ID_W'(1);
          frame_next    = '0;
          busy_next     = 1'b1;
          // Frame 0 is always <= END, so only the start bound matters here.
          active_next   = (start_tbl[pending_id_reg] == '0);
          start_next    = 1'b1;
          cooldown_next = 1'b0;
          cd_cnt_next   = '0;
        end
      end

      // A fresh capture overrides consumption and ageing on the same clock.
      if (capture) begin
        pending_valid_next = 1'b1;
        pending_id_next    = rise_id;
        age_next           = '0;
      end else if (consume) begin
        pending_valid_next = 1'b0;
        age_next           = '0;
      end else if (tick && pending_valid_reg) begin
        if (age_reg == AGE_W'(BUF_FRAMES - 1)) begin
          pending_valid_next = 1'b0;
          age_next           = '0;
        end else begin
          age_next = age_reg + AGE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= IDLE;
      req_d_reg         <= '0;
      pending_valid_reg <= 1'b0;
      pending_id_reg    <= '0;
      age_reg           <= '0;
      atk_id_reg        <= '0;
      type_reg          <= '0;
      frame_reg         <= '0;
      busy_reg          <= 1'b0;
      active_reg        <= 1'b0;
      start_reg         <= 1'b0;
      cooldown_reg      <= 1'b0;
      cd_cnt_reg        <= '0;
    end else begin
      state_reg         <= state_next;
      req_d_reg         <= bus.attack_req;
      pending_valid_reg <= pending_valid_next;
      pending_id_reg    <= pending_id_next;
      age_reg           <= age_next;
      atk_id_reg        <= atk_id_next;
      type_reg          <= type_next;
      frame_reg         <= frame_next;
      busy_reg          <= busy_next;
      active_reg        <= active_next;
      start_reg         <= start_next;
      cooldown_reg      <= cooldown_next;
      cd_cnt_reg        <= cd_cnt_next;
    end
  end

  assign bus.attack_active = active_reg;
  assign bus.attack_type   = type_reg;
  assign bus.attack_frame  = frame_reg;
  assign bus.attack_busy   = busy_reg;
  assign bus.attack_start  = start_reg;
  assign bus.in_cooldown   = cooldown_reg;
endmodule

// File: tb/tb_player_attack_seq.sv
// -----------------------------------------------------------------------------
// tb_player_attack_seq
// Self-checking bench for player_attack_seq with default parameters. A
// frame-level reference model (current attack, frame, cooldown ticks left,
// buffered request and its age) predicts every output each clock; directed
// scenarios add checks against hand-derived constants. Honours
// ATK_COMBO_CHAIN_EN when defined.
// -----------------------------------------------------------------------------
module tb_player_attack_seq;
  localparam int NUM_ATK  = 3;
  localparam int FRAME_W  = 6;
  localparam int RECOVERY = 4;
  localparam int BUF      = 6;
`ifdef ATK_COMBO_CHAIN_EN
  localparam bit COMBO = 1'b1;
`else
  localparam bit COMBO = 1'b0;
`endif

  // Attack i timing: entry 0 is the least significant field of each packed default.
  int m_total [NUM_ATK] = '{18, 26, 12};
  int m_first [NUM_ATK] = '{4, 8, 2};
  int m_last  [NUM_ATK] = '{10, 16, 5};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  player_attack_seq_if #(.NUM_ATK(NUM_ATK), .FRAME_W(FRAME_W)) tb_if ();

  player_attack_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tb_if)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit rand_scen = 1'b0;

  // Reference model state.
  int         m_cur  = -1;
  int         m_frame = 0;
  int         m_cd   = 0;
  int         m_pend = -1;
  int         m_age  = 0;
  logic [2:0] m_reqd = '0;
  bit         m_start = 1'b0;

  // Observation counters used by directed scenarios.
  int cnt_start, cnt_t1, cnt_act, cnt_cd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = -1; m_frame = 0; m_cd = 0; m_pend = -1; m_age = 0;
    m_reqd = '0; m_start = 1'b0;
  endtask

  task automatic model_clk();
    logic [2:0] rise;
    bit tick, consumed;
    rise    = tb_if.attack_req & ~m_reqd;
    m_reqd  = tb_if.attack_req;
    m_start = 1'b0;
    if (tb_if.cancel) begin
      m_cur = -1; m_frame = 0; m_cd = 0; m_pend = -1; m_age = 0;
    end else begin
      tick     = tb_if.SCEN && tb_if.attack_enable;
      consumed = 1'b0;
      if (tick) begin
        if (m_cur >= 0) begin
          if (COMBO && m_pend > m_cur && m_frame > m_last[m_cur]) begin
            m_cur = m_pend; m_frame = 0; m_start = 1'b1; consumed = 1'b1;
          end else if (m_frame == m_total[m_cur] - 1) begin
            m_cur = -1; m_frame = 0; m_cd = RECOVERY;
          end else begin
            m_frame++;
          end
        end else if (m_cd > 0) begin
          m_cd--;
        end else if (m_pend >= 0) begin
          m_cur = m_pend; m_frame = 0; m_start = 1'b1; consumed = 1'b1;
        end
      end
      if (tb_if.attack_enable && rise != 3'b000) begin
        for (int i = NUM_ATK - 1; i >= 0; i--) if (rise[i]) m_pend = i;
        m_age = 0;
      end else if (consumed) begin
        m_pend = -1;
      end else if (tick && m_pend >= 0) begin
        m_age++;
        if (m_age >= BUF) m_pend = -1;
      end
    end
  endtask

  // One clock: drive SCEN, advance the model, then compare every output.
  task automatic step();
    logic [31:0] exp_type;
    bit exp_act;
    if (rand_scen) tb_if.SCEN = ($urandom_range(0, 2) == 0);
    else           tb_if.SCEN = (cyc % 4 == 0);
    if (reset) model_reset();
    else       model_clk();
    @(posedge clk);
    #1;
    cyc++;
    exp_type = (m_cur >= 0) ? 32'(m_cur + 1) : 32'd0;
    exp_act  = (m_cur >= 0) && (m_frame >= m_first[m_cur]) && (m_frame <= m_last[m_cur]);
    check("busy",     32'(tb_if.attack_busy),  32'(m_cur >= 0));
    check("type",     32'(tb_if.attack_type),  exp_type);
    check("frame",    32'(tb_if.attack_frame), 32'(m_frame));
    check("active",   32'(tb_if.attack_active), 32'(exp_act));
    check("start",    32'(tb_if.attack_start), 32'(m_start));
    check("cooldown", 32'(tb_if.in_cooldown),  32'(m_cd > 0));
    if (tb_if.attack_start) cnt_start++;
    if (tb_if.SCEN) begin
      if (tb_if.attack_type == 2'd1) cnt_t1++;
      if (tb_if.attack_active) cnt_act++;
      if (tb_if.in_cooldown) cnt_cd++;
    end
  endtask

  task automatic clear_counts();
    cnt_start = 0; cnt_t1 = 0; cnt_act = 0; cnt_cd = 0;
  endtask

  task automatic press(input logic [2:0] mask);
    tb_if.attack_req = mask;
    step();
    tb_if.attack_req = 3'b000;
  endtask

  task automatic settle(input int budget);
    int n = 0;
    while (!(m_cur < 0 && m_cd == 0 && m_pend < 0) && n < budget) begin
      step();
      n++;
    end
    check("settle_in_time", 32'(n < budget), 32'd1);
    repeat (3) step();
  endtask

  task automatic wait_frame(input int id, input int fr, input int budget);
    int n = 0;
    while (!(m_cur == id && m_frame == fr) && n < budget) begin
      step();
      n++;
    end
    check("reach_frame", 32'(n < budget), 32'd1);
  endtask

  // Counts SCEN ticks until attack_start is seen (bounded).
  task automatic ticks_to_start(output int ticks);
    int n = 0;
    ticks = 0;
    while (!tb_if.attack_start && n < 200) begin
      step();
      n++;
      if (tb_if.SCEN) ticks++;
    end
  endtask

  initial begin
    int n, ticks;
    reset                = 1'b1;
    tb_if.SCEN           = 1'b0;
    tb_if.attack_enable  = 1'b1;
    tb_if.attack_req     = 3'b000;
    tb_if.cancel         = 1'b0;
    model_reset();
    clear_counts();

    // Reset state.
    repeat (3) step();
    #2 reset = 1'b0;
    repeat (4) step();
    $display("[TB] reset released, outputs idle");

    // A: full attack 0 then cooldown.
    clear_counts();
    press(3'b001);
    settle(300);
    check("A_starts", 32'(cnt_start), 32'd1);
    check("A_type1_ticks", 32'(cnt_t1), 32'd18);
    check("A_active_ticks", 32'(cnt_act), 32'd7);
    check("A_cooldown_ticks", 32'(cnt_cd), 32'd4);
    $display("[TB] A: start=%0d type1=%0d active=%0d cd=%0d", cnt_start, cnt_t1, cnt_act, cnt_cd);

    // B: request during attack expires before the attack ends.
    clear_counts();
    press(3'b001);
    wait_frame(0, 3, 200);
    press(3'b100);
    settle(300);
    check("B_single_start", 32'(cnt_start), 32'd1);
    $display("[TB] B: starts=%0d", cnt_start);

    // C: request during cooldown starts on first SCEN after cooldown.
    press(3'b001);
    n = 0;
    while (m_cd != 3 && n < 300) begin step(); n++; end
    check("C_reach_cd", 32'(n < 300), 32'd1);
    press(3'b010);
    n = 0;
    while (tb_if.in_cooldown && n < 100) begin step(); n++; end
    ticks_to_start(ticks);
    check("C_ticks_after_cd", 32'(ticks), 32'd1);
    check("C_type", 32'(tb_if.attack_type), 32'd2);
    $display("[TB] C: ticks=%0d type=%0d", ticks, tb_if.attack_type);
    settle(400);

    // D: simultaneous rises, lowest wins.
    press(3'b101);
    ticks_to_start(ticks);
    check("D_type", 32'(tb_if.attack_type), 32'd1);
    $display("[TB] D: type=%0d", tb_if.attack_type);
    settle(300);

    // E: cancel mid attack 1.
    press(3'b010);
    wait_frame(1, 6, 300);
    tb_if.cancel = 1'b1;
    step();
    tb_if.cancel = 1'b0;
    check("E_busy", 32'(tb_if.attack_busy), 32'd0);
    check("E_active", 32'(tb_if.attack_active), 32'd0);
    check("E_type", 32'(tb_if.attack_type), 32'd0);
    check("E_cooldown", 32'(tb_if.in_cooldown), 32'd0);
    press(3'b001);
    ticks_to_start(ticks);
    check("E_restart_ticks", 32'(ticks), 32'd1);
    check("E_restart_type", 32'(tb_if.attack_type), 32'd1);
    $display("[TB] E: restart ticks=%0d", ticks);
    settle(300);

    // F: late request for attack 1 during attack 0 (chains only when enabled).
    press(3'b001);
    wait_frame(0, 12, 300);
    press(3'b010);
    n = 0;
    do begin step(); n++; end while (!tb_if.SCEN && n < 8);
    check("F_type", 32'(tb_if.attack_type), COMBO ? 32'd2 : 32'd1);
    check("F_frame", 32'(tb_if.attack_frame), COMBO ? 32'd0 : 32'd13);
    $display("[TB] F: type=%0d frame=%0d", tb_if.attack_type, tb_if.attack_frame);
    settle(400);

    // G: enable low freezes the attack.
    press(3'b001);
    wait_frame(0, 5, 300);
    tb_if.attack_enable = 1'b0;
    repeat (40) step();
    check("G_frame_hold", 32'(tb_if.attack_frame), 32'd5);
    check("G_active_hold", 32'(tb_if.attack_active), 32'd1);
    tb_if.attack_enable = 1'b1;
    n = 0;
    do begin step(); n++; end while (!tb_if.SCEN && n < 8);
    check("G_resume_frame", 32'(tb_if.attack_frame), 32'd6);
    $display("[TB] G: resumed at frame %0d", tb_if.attack_frame);
    settle(300);

    // H: asynchronous reset mid attack 1.
    press(3'b010);
    wait_frame(1, 10, 300);
    #2 reset = 1'b1;
    #1;
    check("H_busy", 32'(tb_if.attack_busy), 32'd0);
    check("H_type", 32'(tb_if.attack_type), 32'd0);
    check("H_frame", 32'(tb_if.attack_frame), 32'd0);
    check("H_active", 32'(tb_if.attack_active), 32'd0);
    model_reset();
    repeat (3) step();
    reset = 1'b0;
    clear_counts();
    repeat (40) step();
    check("H_no_start", 32'(cnt_start), 32'd0);
    $display("[TB] H: starts after reset=%0d", cnt_start);

    // Random phase against the model.
    rand_scen = 1'b1;
    repeat (3000) begin
      if ($urandom_range(0, 5) == 0) tb_if.attack_req = 3'($urandom_range(0, 7));
      tb_if.attack_enable = ($urandom_range(0, 15) != 0);
      tb_if.cancel        = ($urandom_range(0, 47) == 0);
      step();
    end
    $display("[TB] random phase done at cycle %0d", cyc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
